reg_dump_unit: RTL and testbench
================================

REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

Interface
REQ-001 Parameter FIRST_REG, default 0: index of the first register read out; valid range 0..31.
REQ-002 Parameter LAST_REG, default 31: index of the last register read out; FIRST_REG <= LAST_REG.
REQ-003 CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  dump request; sampled only in IDLE.
REQ-006 rsel  out  5  read select driven to the register file read port.
REQ-007 rdat  in  32  combinational read data returned by the register file for rsel.
REQ-008 dump_valid  out  1  dump_data/dump_idx hold a valid beat.
REQ-009 dump_ready  in  1  consumer accepts the beat.
REQ-010 dump_data  out  32  captured register value (word_t).
REQ-011 dump_idx  out  5  register index of dump_data.
REQ-012 busy  out  1  high in every state except IDLE; the core stalls its register writes while busy.
REQ-013 done  out  1  single-cycle pulse after the last beat is accepted.

Function
REQ-014 The block SHALL implement the FSM states IDLE, LOAD, SEND and DONE.
REQ-015 IDLE: rsel=0, dump_valid=0, busy=0; start=1 at an edge SHALL load idx=FIRST_REG and move to LOAD.
REQ-016 LOAD: rsel=idx; the next edge SHALL capture rdat into dump_data and idx into dump_idx, then move to SEND.
REQ-017 SEND: dump_valid=1; dump_data and dump_idx SHALL remain stable while dump_valid=1 and dump_ready=0.
REQ-018 SEND with dump_ready=1 at an edge: if idx==LAST_REG move to DONE, else idx<=idx+1 and move to LOAD.
REQ-019 DONE SHALL assert done for exactly one cycle, then move to IDLE; idx SHALL return to 0.
REQ-020 start SHALL be ignored in LOAD, SEND and DONE; no queued request.
REQ-021 Latency: start sampled at edge n gives LOAD in cycle n+1 and the first dump_valid in cycle n+2.
REQ-022 The minimum cost is 2 cycles per register; a full 32-register dump with dump_ready tied high SHALL produce done 65 cycles after the start edge.
REQ-023 idx SHALL never exceed LAST_REG; there is no wrap-around to FIRST_REG within a dump.
REQ-024 Register 0 SHALL be read like any other register, and its beat SHALL carry the value the file returns (0).
REQ-025 start=1 held continuously SHALL start a new dump on the first IDLE cycle after DONE.
REQ-026 rsel SHALL be driven from state only, with no combinational path from start, dump_ready or rdat.

Reset
REQ-027 RST=1 SHALL force state IDLE, idx=0, rsel=0, dump_valid=0, dump_data=0, dump_idx=0, busy=0 and done=0 immediately, without waiting for CLK.
REQ-028 RST asserted mid-dump SHALL abort the dump with no done pulse; after release, the block waits for a fresh start.

Structure
REQ-029 word_t (32 bits) and regbits_t (5 bits) SHALL come from cpu_types_pkg; the dump_state_t enum SHALL be added to cpu_types_pkg.
REQ-030 The block SHALL be a single module without sub-modules; it connects to the register file read port rsel1/rdat1 at the top level.

Verification
REQ-031 Registers preloaded with value 0x100+i (i=1..31), start pulse, dump_ready=1 -> 32 beats with idx 0..31 and data 0, 0x101..0x11F; done at start+65 cycles.
REQ-032 Random dump_ready with 50% stalls -> dump_data and dump_idx stable across every stalled cycle; no beat lost or duplicated; done exactly once.
REQ-033 FIRST_REG=5, LAST_REG=7, dump_ready=1 -> exactly 3 beats (idx 5, 6, 7); done at start+7 cycles.
REQ-034 RST pulsed between edges during the SEND of idx 10 -> dump_valid and busy low before the next edge; no done; a new start restarts the dump at idx 0.
REQ-035 start re-pulsed while busy -> ignored, beat count stays 32; start held high -> a second dump begins in the cycle after done.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, register index and the
// state encoding of the register dump sequencer.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  localparam int REG_COUNT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/reg_dump_unit.sv
// Walks register file entries FIRST_REG..LAST_REG through the single read
// port and streams each value out as a valid/ready beat tagged with its index.
module reg_dump_unit
  import cpu_types_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  output logic [4:0]  rsel,
  input  logic [31:0] rdat,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_data,
  output logic [4:0]  dump_idx,
  output logic        busy,
  output logic        done
);

  localparam regbits_t FIRST_IDX = regbits_t'(FIRST_REG);
  localparam regbits_t LAST_IDX  = regbits_t'(LAST_REG);

  dump_state_t state_reg, state_next;
  regbits_t    idx_reg;
  word_t       data_reg;
  regbits_t    didx_reg;

  logic last_beat;
  assign last_beat = (idx_reg == LAST_IDX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = LOAD;
      LOAD: state_next = SEND;
      SEND: if (dump_ready) state_next = last_beat ? DONE : LOAD;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // rsel depends on registered state only, so the read port never sees
  // a combinational path from the handshake or the returned data.
  always_comb begin
    rsel       = (state_reg == LOAD) ? idx_reg : '0;
    dump_valid = (state_reg == SEND);
    busy       = (state_reg != IDLE);
    done       = (state_reg == DONE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start) idx_reg <= FIRST_IDX;
        SEND: if (dump_ready && !last_beat) idx_reg <= idx_reg + 5'd1;
        DONE: idx_reg <= '0;
        default: idx_reg <= idx_reg;
      endcase
    end
  end

  // Beat payload is captured once in LOAD and held through any SEND stall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_reg <= '0;
      didx_reg <= '0;
    end else if (state_reg == LOAD) begin
      data_reg <= rdat;
      didx_reg <= idx_reg;
    end
  end

  assign dump_data = data_reg;
  assign dump_idx  = didx_reg;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: full dumps, stalls, sub-range dump,
// mid-dump reset, start re-pulse and start held high.
module tb_reg_dump_unit;

  logic        CLK;
  logic        RST;
  logic        start_a, start_b;
  logic        dump_ready;
  logic [4:0]  rsel_a, rsel_b;
  logic [31:0] rdat_a, rdat_b;
  logic        valid_a, valid_b;
  logic [31:0] data_a, data_b;
  logic [4:0]  idx_a, idx_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;

  int passed = 0;
  int total  = 0;

  function automatic logic [31:0] regval(input logic [4:0] r);
    return (r == 5'd0) ? 32'h0 : (32'h100 + {27'b0, r});
  endfunction

  assign rdat_a = regval(rsel_a);
  assign rdat_b = regval(rsel_b);

  reg_dump_unit dut_a (
    .CLK(CLK), .RST(RST), .start(start_a), .rsel(rsel_a), .rdat(rdat_a),
    .dump_valid(valid_a), .dump_ready(dump_ready), .dump_data(data_a),
    .dump_idx(idx_a), .busy(busy_a), .done(done_a)
  );

  reg_dump_unit #(.FIRST_REG(5), .LAST_REG(7)) dut_b (
    .CLK(CLK), .RST(RST), .start(start_b), .rsel(rsel_b), .rdat(rdat_b),
    .dump_valid(valid_b), .dump_ready(dump_ready), .dump_data(data_b),
    .dump_idx(idx_b), .busy(busy_b), .done(done_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // Cycle c counts from the start edge: c=1 is the LOAD cycle, so the
  // first beat is visible at c=2 and a full 32-entry dump ends with done at c=65.
  task automatic run_dump(input bit sel, input int stall_pct, input bit hold,
                          input bit repulse, input bit skip_start,
                          input int first, input int last, input int exp_done);
    int exp_idx = first;
    int beats = 0;
    int dones = 0;
    int done_c = 0;
    bit prev_stall = 0;
    logic [31:0] pd = '0;
    logic [4:0]  pi = '0;
    logic v, dn, bz;
    logic [31:0] d;
    logic [4:0]  i, rs;
    if (!skip_start) begin
      @(negedge CLK); set_start(sel, 1'b1);
      @(negedge CLK); set_start(sel, hold);
    end
    for (int c = 1; c <= 600; c++) begin
      dump_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
      if (repulse) set_start(sel, (c == 10 || c == 30));
      v  = sel ? valid_b : valid_a;
      d  = sel ? data_b  : data_a;
      i  = sel ? idx_b   : idx_a;
      dn = sel ? done_b  : done_a;
      bz = sel ? busy_b  : busy_a;
      rs = sel ? rsel_b  : rsel_a;
      if (c == 1) begin
        check("load_busy", 32'(bz), 32'd1);
        check("load_valid", 32'(v), 32'd0);
        check("load_rsel", 32'(rs), 32'(first));
      end
      if (c == 2) check("first_valid_latency", 32'(v), 32'd1);
      if (v) begin
        if (prev_stall) begin
          check("stall_data_stable", d, pd);
          check("stall_idx_stable", 32'(i), 32'(pi));
        end
        if (dump_ready) begin
          check("beat_idx", 32'(i), 32'(exp_idx));
          check("beat_data", d, regval(5'(exp_idx)));
          $display("beat cycle=%0d idx=%0d data=0x%0h", c, i, d);
          exp_idx++;
          beats++;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          pd = d;
          pi = i;
        end
      end
      if (dn) begin
        dones++;
        if (dones == 1) done_c = c;
      end
      if (dones > 0 && c == done_c + 1) begin
        check("done_single_cycle", 32'(dn), 32'd0);
        check("idle_after_done", 32'(bz), 32'd0);
        break;
      end
      @(negedge CLK);
    end
    check("done_count", 32'(dones), 32'd1);
    check("beat_count", 32'(beats), 32'(last - first + 1));
    if (exp_done >= 0) check("done_cycle", 32'(done_c), 32'(exp_done));
    $display("dump sel=%0d beats=%0d done_cycle=%0d", sel, beats, done_c);
  endtask

  initial begin
    int found;
    int stray_done;
    RST = 1'b1; start_a = 1'b0; start_b = 1'b0; dump_ready = 1'b0;
    #2;
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_rsel", 32'(rsel_a), 32'd0);
    check("rst_data", data_a, 32'd0);
    check("rst_idx", 32'(idx_a), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("idle_busy", 32'(busy_a), 32'd0);

    // Full dump, consumer always ready.
    run_dump(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 31, 65);
    // Sub-range dump on the second instance.
    run_dump(1'b1, 0, 1'b0, 1'b0, 1'b0, 5, 7, 7);
    // Random 50% back-pressure.
    run_dump(1'b0, 50, 1'b0, 1'b0, 1'b0, 0, 31, -1);
    // start re-pulsed while busy is ignored.
    run_dump(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 31, 65);

    // Reset between edges while idx 10 is on offer.
    @(negedge CLK); start_a = 1'b1;
    @(negedge CLK); start_a = 1'b0;
    dump_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      if (valid_a && idx_a == 5'd10) begin
        found = 1;
        break;
      end
      @(negedge CLK);
    end
    check("reached_idx10", 32'(found), 32'd1);
    #1 RST = 1'b1;
    #1;
    check("midrst_valid", 32'(valid_a), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_done", 32'(done_a), 32'd0);
    check("midrst_data", data_a, 32'd0);
    check("midrst_idx", 32'(idx_a), 32'd0);
    #1 RST = 1'b0;
    stray_done = 0;
    repeat (10) begin
      @(negedge CLK);
      if (done_a || busy_a) stray_done++;
    end
    check("no_done_after_abort", 32'(stray_done), 32'd0);
    run_dump(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 31, 65);

    // start held high: a second dump follows straight after done.
    run_dump(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 31, 65);
    @(negedge CLK); start_a = 1'b0;
    run_dump(1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 31, 65);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
